dct_transpose: RTL and testbench
================================

DCT_TRANSPOSE -- requirements
Module: dct_transpose

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, the signed sample width (the 1-D DCT output width).
REQ-002 SHALL have parameter N, default 8, the block dimension; only N=8 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the row-pass 1-D DCT presents a row on d0..d7.
REQ-006 SHALL have ports d0..d7, input, DATA_WIDTH each, signed: row coefficients y0..y7 of the row-pass DCT.
REQ-007 SHALL have port in_ready, output, 1 bit: the current write bank can accept a row.
REQ-008 SHALL have ports q0..q7, output, DATA_WIDTH each, signed: one column of the block, q_i = row i of the stored block.
REQ-009 SHALL have port out_valid, output, 1 bit: q0..q7 hold a valid column.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream column-pass DCT accepts the column.
REQ-011 SHALL have port out_last, output, 1 bit: the current column is column 7 of the block.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set when in_valid arrives while in_ready is 0.

Function
REQ-013 SHALL hold two N x N register banks (ping-pong), a write-bank pointer wr_bank, a 3-bit row counter wr_row, a read-bank pointer rd_bank, a 3-bit column counter rd_col, and full[1:0] flags.
REQ-014 SHALL drive in_ready = !full[wr_bank], combinationally.
REQ-015 SHALL, on in_valid && in_ready, write d0..d7 into bank[wr_bank] row wr_row, columns 0..7, and then increment wr_row.
REQ-016 SHALL, when a row is accepted at wr_row=7, set full[wr_bank], toggle wr_bank and wrap wr_row to 0.
REQ-017 SHALL drive out_valid = full[rd_bank]; the first column is valid in the cycle after the 8th row is accepted (latency 1).
REQ-018 SHALL drive q_i = bank[rd_bank][row i][rd_col] when out_valid is 1, and 0 when out_valid is 0.
REQ-019 SHALL drive out_last = out_valid && (rd_col == 7).
REQ-020 SHALL, on out_valid && out_ready, increment rd_col; at rd_col=7 it SHALL clear full[rd_bank], toggle rd_bank and wrap rd_col to 0.
REQ-021 SHALL, while out_valid is 1 and out_ready is 0, hold q0..q7, out_last and rd_col stable.
REQ-022 SHALL allow a bank to be freed and the other bank to be filled in the same cycle; if both happen on one bank index, set and clear SHALL both apply to their own bank without interference.
REQ-023 SHALL drop a row presented while in_ready=0, leave all state unchanged, and set overflow until reset.
REQ-024 SHALL pass data through without arithmetic: no rounding, saturation or width change.

Reset
REQ-025 SHALL, on rst=1, asynchronously clear wr_bank, wr_row, rd_bank, rd_col, full[1:0] and overflow to 0, so that in_ready=1, out_valid=0, out_last=0 and q0..q7=0.
REQ-026 SHALL not reset bank storage; contents become visible only after 8 rows have been written.
REQ-027 SHALL, when reset is asserted mid-block, discard any partial rows and any unread columns.

Structure
REQ-028 SHALL place DATA_WIDTH, N and the row/column index width in shared package dct_pkg, used by dct1D users as well.
REQ-029 SHALL implement each 8x8 store as sub-module dct_tp_bank (row write port, column read mux), instantiated twice.

Verification
REQ-030 Single block: rows r=0..7 with d_c = 8r+c, out_ready=1 -> 8 consecutive columns c=0..7 with q_i = 8i+c, out_valid first in the cycle after row 7, out_last on column 7.
REQ-031 Signed extremes: all samples -512 in one block, then +511 in the next, out_ready=1 -> columns show exactly -512 then +511, with no sign corruption.
REQ-032 Back-to-back: 3 blocks streamed with in_valid=1 continuously and out_ready=1 -> in_ready never drops, 24 columns are emitted in order, and the banks alternate.
REQ-033 Backpressure: out_ready=0 while 16 rows are sent -> in_ready=0 after the 16th row; the 17th row raises overflow and is dropped; releasing out_ready yields the block-1 and block-2 columns intact.
REQ-034 Stall mid-block: out_ready toggles 1,0,0,1 during read -> q is held during the stall and no column is skipped or duplicated.
REQ-035 Reset mid-operation: assert rst after 5 rows -> out_valid=0, in_ready=1, overflow=0; a following full block is transposed correctly.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants for the 2-D DCT datapath: sample width, block size and
// the row/column index width used by the row pass, transpose and column pass.
package dct_pkg;
  localparam int DATA_WIDTH = 10;
  localparam int N          = 8;
  localparam int IDX_W      = 3;
endpackage

// File: rtl/dct_tp_bank.sv
// One N x N coefficient store: a full row is written per cycle, and a full
// column is read combinationally. Storage is deliberately not reset.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int NB = N
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wr_row,
  input  logic [NB-1:0][DW-1:0]  wr_data,
  input  logic [IDX_W-1:0]       rd_col,
  output logic [NB-1:0][DW-1:0]  rd_data
);

  logic [NB-1:0][NB-1:0][DW-1:0] mem_q;
  logic [NB-1:0][NB-1:0][DW-1:0] mem_d;

  // Next-state of the store: replace one row on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_row] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage register, intentionally without reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Column read mux: element i of the output is row i at the selected column.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      rd_data[i] = mem_q[i][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong transpose buffer between the row-pass and column-pass 1-D DCTs:
// accepts 8 rows into one bank while the other bank is drained column by column.
module dct_transpose #(
  parameter int DATA_WIDTH = dct_pkg::DATA_WIDTH,
  parameter int N          = dct_pkg::N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] d0,
  input  logic signed [DATA_WIDTH-1:0] d1,
  input  logic signed [DATA_WIDTH-1:0] d2,
  input  logic signed [DATA_WIDTH-1:0] d3,
  input  logic signed [DATA_WIDTH-1:0] d4,
  input  logic signed [DATA_WIDTH-1:0] d5,
  input  logic signed [DATA_WIDTH-1:0] d6,
  input  logic signed [DATA_WIDTH-1:0] d7,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] q0,
  output logic signed [DATA_WIDTH-1:0] q1,
  output logic signed [DATA_WIDTH-1:0] q2,
  output logic signed [DATA_WIDTH-1:0] q3,
  output logic signed [DATA_WIDTH-1:0] q4,
  output logic signed [DATA_WIDTH-1:0] q5,
  output logic signed [DATA_WIDTH-1:0] q6,
  output logic signed [DATA_WIDTH-1:0] q7,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow
);
  import dct_pkg::*;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d;
  logic [IDX_W-1:0] rd_col_q, rd_col_d;

  logic wr_fire;
  logic rd_fire;
  vec_t wr_vec;
  vec_t rd_vec0;
  vec_t rd_vec1;
  vec_t rd_vec;

  assign wr_vec    = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_col_q == LAST_IDX);
  assign overflow  = overflow_q;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  dct_tp_bank #(.DW(DATA_WIDTH), .NB(N)) u_bank0 (
    .clk     (clk),
    .we      (wr_fire && !wr_bank_q),
    .wr_row  (wr_row_q),
    .wr_data (wr_vec),
    .rd_col  (rd_col_q),
    .rd_data (rd_vec0)
  );

  dct_tp_bank #(.DW(DATA_WIDTH), .NB(N)) u_bank1 (
    .clk     (clk),
    .we      (wr_fire && wr_bank_q),
    .wr_row  (wr_row_q),
    .wr_data (wr_vec),
    .rd_col  (rd_col_q),
    .rd_data (rd_vec1)
  );

  // Next-state for pointers and bank flags; the clear and set each target
  // their own bank index, and a full bank cannot also be the write bank.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_col_d   = rd_col_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_col_d = rd_col_q;
    end
    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_row_d = wr_row_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= 3'd0;
      rd_col_q   <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
      overflow_q <= overflow_d;
    end
  end

  // Column output: zeroed whenever no valid column is presented.
  always_comb begin
    rd_vec = rd_bank_q ? rd_vec1 : rd_vec0;
    if (out_valid) begin
      q0 = rd_vec[0];
      q1 = rd_vec[1];
      q2 = rd_vec[2];
      q3 = rd_vec[3];
      q4 = rd_vec[4];
      q5 = rd_vec[5];
      q6 = rd_vec[6];
      q7 = rd_vec[7];
    end else begin
      q0 = {DATA_WIDTH{1'b0}};
      q1 = {DATA_WIDTH{1'b0}};
      q2 = {DATA_WIDTH{1'b0}};
      q3 = {DATA_WIDTH{1'b0}};
      q4 = {DATA_WIDTH{1'b0}};
      q5 = {DATA_WIDTH{1'b0}};
      q6 = {DATA_WIDTH{1'b0}};
      q7 = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Bench for dct_transpose: a queue-of-blocks model checked every cycle,
// plus literal expectations at hand-computed points of each scenario.
module tb_dct_transpose;

  logic clk = 1'b0;
  logic rst;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [9:0] dv [8];
  logic signed [9:0] qv [8];
  logic in_ready, out_valid, out_last, overflow;

  int nerr = 0;
  int nchk = 0;

  // Model: completed blocks queued row-major (64 ints each), rows of the
  // block being filled, the column being presented, and the sticky flag.
  int mq[$];
  int part[$];
  int m_col = 0;
  bit m_ovf = 1'b0;
  bit m_rdy, m_vld;

  always #5 clk = ~clk;

  dct_transpose dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
    .in_ready(in_ready),
    .q0(qv[0]), .q1(qv[1]), .q2(qv[2]), .q3(qv[3]),
    .q4(qv[4]), .q5(qv[5]), .q6(qv[6]), .q7(qv[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      part.delete();
      m_col = 0;
      m_ovf = 1'b0;
    end else begin
      m_rdy = mq.size() < 128;
      m_vld = mq.size() >= 64;
      if (in_valid && !m_rdy) m_ovf = 1'b1;
      if (m_vld && out_ready) begin
        if (m_col == 7) begin
          repeat (64) void'(mq.pop_front());
          m_col = 0;
        end else begin
          m_col++;
        end
      end
      if (in_valid && m_rdy) begin
        for (int c = 0; c < 8; c++) part.push_back(int'(dv[c]));
        if (part.size() == 64) begin
          foreach (part[k]) mq.push_back(part[k]);
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = mq.size() >= 64;
    chk("in_ready", int'(in_ready), int'(mq.size() < 128));
    chk("out_valid", int'(out_valid), int'(ev));
    chk("out_last", int'(out_last), int'(ev && m_col == 7));
    chk("overflow", int'(overflow), int'(m_ovf));
    for (int i = 0; i < 8; i++)
      chk($sformatf("q%0d", i), int'(qv[i]), ev ? mq[i*8 + m_col] : 0);
  end

  task automatic send_row(input int base, input int step, input int r);
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) dv[c] = 10'(base + step * (8*r + c));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 8; c++) dv[c] = 10'sd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q0", int'(qv[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single block d_c = 8r+c.
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row(0, 1, r);
    in_valid = 1'b0;
    chk("blk_first_valid", int'(out_valid), 1);
    chk("blk_c0_q3", int'(qv[3]), 24);
    chk("blk_c0_last", int'(out_last), 0);
    repeat (7) @(negedge clk);
    chk("blk_c7_q7", int'(qv[7]), 63);
    chk("blk_c7_last", int'(out_last), 1);
    @(negedge clk);
    chk("blk_done_valid", int'(out_valid), 0);

    // Signed extremes.
    for (int r = 0; r < 8; r++) send_row(-512, 0, r);
    in_valid = 1'b0;
    chk("neg_q5", int'(qv[5]), -512);
    for (int r = 0; r < 8; r++) send_row(511, 0, r);
    in_valid = 1'b0;
    chk("pos_q2", int'(qv[2]), 511);
    idle(8);

    // Three blocks back to back.
    for (int r = 0; r < 8; r++) send_row(0, 5, r);
    for (int r = 0; r < 8; r++) send_row(400, -13, r);
    for (int r = 0; r < 8; r++) send_row(-100, 3, r);
    in_valid = 1'b0;
    chk("b2b_blk2_q0", int'(qv[0]), -100);
    idle(9);

    // Backpressure with overflow on the 17th row.
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(-300, 1, r);
    for (int r = 0; r < 8; r++) send_row(300, -1, r);
    in_valid = 1'b0;
    chk("bp_in_ready", int'(in_ready), 0);
    send_row(0, 1, 0);
    in_valid = 1'b0;
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_q0", int'(qv[0]), -300);
    out_ready = 1'b1;
    idle(17);

    // Stall mid-block: out_ready 1,0,0,1.
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(200, 1, r);
    in_valid = 1'b0;
    chk("st_c0", int'(qv[0]), 200);
    out_ready = 1'b1;
    @(negedge clk);
    chk("st_c1", int'(qv[0]), 201);
    out_ready = 1'b0;
    @(negedge clk);
    chk("st_hold1", int'(qv[0]), 201);
    @(negedge clk);
    chk("st_hold2", int'(qv[0]), 201);
    out_ready = 1'b1;
    @(negedge clk);
    chk("st_c2", int'(qv[0]), 202);
    idle(8);

    // Reset after five rows.
    for (int r = 0; r < 5; r++) send_row(7, 2, r);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_overflow", int'(overflow), 0);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 8; r++) send_row(-50, 3, r);
    in_valid = 1'b0;
    chk("mr_q7", int'(qv[7]), 118);
    idle(9);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
